// File: rtl/uart_pkg.sv
// Shared UART types and constants.
// Detector state encoding and FIFO entry layout.
package uart_pkg;

  localparam int DATA_BITS     = 8;
  localparam int TICKS_PER_BIT = 16;

  typedef enum logic [0:0] {
    DET_IDLE,
    DET_LOW
  } det_state_e;

  typedef struct packed {
    logic                 frame_err;
    logic [DATA_BITS-1:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Generic first-word-fall-through FIFO with occupancy count.
// Ports: push_i/wr_data_i, pop_i/rd_data_o, full_o, empty_o, count_o.
module uart_sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0] count_q, count_d;
  logic        do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign do_pop  = pop_i & ~empty_o;
  // A same-cycle pop frees the slot, so full does not block the write.
  assign do_push = push_i & (~full_o | do_pop);

  assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];
  assign count_o   = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case (1'b1)
      do_push & ~do_pop: count_d = count_q + 1'b1;
      do_pop & ~do_push: count_d = count_q - 1'b1;
      default:           count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// Turns completed UART receiver frames into FIFO entries on a
// valid/ready stream, with frame-error tag and sticky overflow.
// In: rx_baud_tick/rx_ready/rx_data/rx_error, m_ready, clear_overflow.
// Out: m_valid/m_data/m_frame_err, fifo_count, overflow.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_BITS     = uart_pkg::DATA_BITS,
  parameter int DEPTH         = 16,
  parameter int MIN_LOW_TICKS = TICKS_PER_BIT * (DATA_BITS + 1),
  localparam int AW  = $clog2(DEPTH),
  localparam int LCW = $clog2(MIN_LOW_TICKS + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_baud_tick,
  input  logic                 rx_ready,
  input  logic [DATA_BITS-1:0] rx_data,
  input  logic                 rx_error,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [DATA_BITS-1:0] m_data,
  output logic                 m_frame_err,
  output logic [AW:0]          fifo_count,
  output logic                 overflow,
  input  logic                 clear_overflow
);

  localparam logic [LCW-1:0] MIN_CNT = LCW'(MIN_LOW_TICKS);

  det_state_e     state_q, state_d;
  logic           armed_q, armed_d;
  logic [LCW-1:0] low_cnt_q, low_cnt_d;
  logic           rdy_q;
  logic           ovf_q, ovf_d;
  logic           fall, rise, cap;
  logic           full, empty, pop, drop;
  logic [DATA_BITS:0] rd_word;

  assign fall = rdy_q & ~rx_ready;
  assign rise = ~rdy_q & rx_ready;

  always_comb begin
    state_d   = state_q;
    armed_d   = armed_q;
    low_cnt_d = low_cnt_q;
    cap       = 1'b0;
    unique case (state_q)
      DET_IDLE: begin
        if (fall) begin
          state_d   = DET_LOW;
          low_cnt_d = '0;
          armed_d   = 1'b1;
        end else if (rise) begin
          armed_d = 1'b0;
        end
      end
      DET_LOW: begin
        if (rise) begin
          // Short lows are aborted start bits; only full frames count.
          cap     = armed_q && (low_cnt_q >= MIN_CNT);
          armed_d = 1'b0;
          state_d = DET_IDLE;
        end else if (rx_baud_tick && (low_cnt_q != MIN_CNT)) begin
          low_cnt_d = low_cnt_q + 1'b1;
        end
      end
      default: state_d = DET_IDLE;
    endcase
  end

  assign pop  = m_valid & m_ready;
  assign drop = cap & full & ~pop;

  always_comb begin
    ovf_d = ovf_q;
    if (clear_overflow) ovf_d = 1'b0;
    if (drop)           ovf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= DET_IDLE;
      armed_q   <= 1'b0;
      low_cnt_q <= '0;
      rdy_q     <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      armed_q   <= armed_d;
      low_cnt_q <= low_cnt_d;
      rdy_q     <= rx_ready;
      ovf_q     <= ovf_d;
    end
  end

  uart_sync_fifo #(
    .WIDTH (DATA_BITS + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_i    (cap),
    .wr_data_i ({rx_error, rx_data}),
    .pop_i     (pop),
    .rd_data_o (rd_word),
    .full_o    (full),
    .empty_o   (empty),
    .count_o   (fifo_count)
  );

  assign m_valid     = ~empty;
  assign m_data      = rd_word[DATA_BITS-1:0];
  assign m_frame_err = rd_word[DATA_BITS];
  assign overflow    = ovf_q;

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Sits directly downstream of the UART receiver. It consumes the receiver's level-style rx_ready, rx_data and rx_error outputs and turns each completed frame into one FIFO entry.
- Frame-completion detection rejects the post-reset ready assertion and aborted (noise) start bits.
- Buffered bytes are presented to the system side on a valid/ready stream, with frame-error tagging and a sticky overflow flag.

Parameters:
- DATA_BITS, 8: data bits per frame; must match the receiver.
- DEPTH, 16: FIFO entries; power of 2, minimum 2.
- MIN_LOW_TICKS, 16*(DATA_BITS+1): minimum rx_baud_tick count while rx_ready is low for the frame to count as genuine.

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- rx_baud_tick  in  1  16x baud tick, the same strobe that drives the receiver
- rx_ready  in  1  receiver ready level: low while receiving, high when idle
- rx_data  in  DATA_BITS  receiver parallel data
- rx_error  in  1  receiver frame-error flag
- m_valid  out  1  FIFO non-empty
- m_ready  in  1  consumer accept
- m_data  out  DATA_BITS  head entry data
- m_frame_err  out  1  head entry frame-error tag
- fifo_count  out  $clog2(DEPTH)+1  occupancy
- overflow  out  1  sticky: a frame was dropped because the FIFO was full
- clear_overflow  in  1  synchronous clear of overflow

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk. All state clears: pointers=0, fifo_count=0, m_valid=0, overflow=0, armed=0, low_cnt=0, rdy_q=0. m_data and m_frame_err are don't-care while m_valid=0. Reset mid-frame discards any partial detection state and all FIFO contents.
- Frame detector FSM, states IDLE, LOW, and the combinational CHECK decision:
  - IDLE: on rdy_q=1 and rx_ready=0 (falling edge), go to LOW, clear low_cnt, set armed=1.
  - LOW: low_cnt increments on each rx_baud_tick and saturates at MIN_LOW_TICKS.
  - Rising edge (rdy_q=0, rx_ready=1): if armed and low_cnt≥MIN_LOW_TICKS, generate a 1-cycle capture strobe, sampling {rx_error, rx_data} on that same cycle. Otherwise (aborted start, low_cnt about 8) no capture. Either way, clear armed and return to IDLE.
  - The rising edge right after reset has armed=0, so nothing is captured.
- Capture latency: the rising edge of rx_ready is seen at cycle N, the entry is written at the N+1 clock edge, and m_valid rises at N+1 if the FIFO was empty.
- FIFO behaviour:
  - Storage: DEPTH x (DATA_BITS+1) register array.
  - Read side: first-word-fall-through. m_data and m_frame_err are driven combinationally from mem[rd_ptr].
  - Pointers: ADDR_W+1 bits with natural wrap. Full when the MSBs differ and the low bits are equal; empty when the pointers are equal.
  - Pop: m_valid & m_ready.
  - Push: capture strobe & (not full, or pop in the same cycle).
  - Simultaneous push and pop: allowed at any occupancy including full; fifo_count is unchanged.
  - Capture while full with no pop: the entry is dropped and overflow is set to 1. FIFO contents and pointers are untouched.
  - Overflow clearing: clear_overflow=1 clears overflow next cycle. If a drop occurs in the same cycle, the set wins.
  - m_valid must hold stable with m_ready low; m_data must not change while m_valid=1 and no pop occurs.
- fifo_count: registered. Increments on push-only, decrements on pop-only, unchanged otherwise; range 0..DEPTH.

Decomposition:
- Shared package uart_pkg holds:
  - DATA_BITS default
  - TICKS_PER_BIT=16
  - detector state enum {DET_IDLE, DET_LOW}
  - the FIFO entry struct {frame_err, data}
- One natural sub-module, uart_sync_fifo (generic FWFT FIFO with count and full/empty). It is reusable by the TX side. The detector stays inline in uart_rx_fifo.

Test Plan:
- Reset release, receiver idles with rx_ready rising at the first cycle -> no push, fifo_count=0, m_valid=0.
- Three frames 0x55, 0xA3, 0x00 (rx_error=0; rx_ready low for 150 ticks each), m_ready=0 -> fifo_count=3, m_data=0x55, m_frame_err=0. Then m_ready=1 -> bytes out in order 0x55, 0xA3, 0x00 on consecutive cycles, after which m_valid=0.
- Aborted start: rx_ready low for 8 ticks then high -> no push. A following genuine 0x3C frame -> exactly one entry, 0x3C.
- Frame with rx_error=1, rx_data=0xFF -> entry m_data=0xFF, m_frame_err=1.
- DEPTH=16: 17 frames with m_ready=0 -> fifo_count=16, overflow=1, head still the first byte. clear_overflow pulse -> overflow=0. Full FIFO with capture and pop in the same cycle -> fifo_count stays 16, overflow unchanged.
- Assert rst during LOW of a frame and with fifo_count=5 -> all outputs reset at once. The subsequent rising edge of rx_ready is not captured, since armed=0.
